mul64_dot_acc: RTL and testbench
================================

// Module: mul64_dot_acc
// PURPOSE
//  Downstream consumer of the 64x64 multiplier: accepts a burst of 128-bit products over a
//  valid/ready handshake and sums them into a wide accumulator (dot-product reduction).
//  A start command sets the burst length. The final sum is presented on a valid/ready output.
//  A sticky flag reports accumulator overflow.
// PARAMETERS
//  PROD_W  128  product width; matches multiplier result width
//  ACC_W   136  accumulator width; must be >= PROD_W; 256 full-scale products fit without overflow
//  CNT_W   16   width of burst-length counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       single-cycle command; sampled only in IDLE
//  len        in   CNT_W   number of products in the burst; sampled with start
//  clear      in   1       synchronous abort; returns the block to IDLE
//  prod       in   PROD_W  unsigned product from the multiplier
//  prod_valid in   1       prod is valid this cycle
//  prod_ready out  1       block accepts prod this cycle
//  acc_out    out  ACC_W   accumulated sum
//  acc_valid  out  1       acc_out is final
//  acc_ready  in   1       downstream takes acc_out
//  overflow   out  1       sticky; a carry left bit ACC_W-1 during this burst
//  busy       out  1       high in ACCUM and DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. acc_out, acc_valid, prod_ready, overflow, busy and the counter all 0.
//  - FSM states: IDLE, ACCUM, DONE. The block never processes more than one burst at a time.
//  - IDLE: prod_ready=0, busy=0.
//      start=1, len>0: next cycle acc_out=0, overflow=0, rem=len, state=ACCUM.
//      start=1, len=0: next cycle acc_out=0, overflow=0, state=DONE.
//  - ACCUM: prod_ready=1, taken combinationally from state. A transfer occurs when prod_valid&&prod_ready.
//      On each transfer: acc_out <= acc_out + zero-extend(prod), truncated to ACC_W; rem <= rem-1;
//      overflow <= overflow | carry-out of the ACC_W-bit add.
//      On the transfer with rem==1, state goes to DONE on the same edge.
//      acc_valid rises 1 cycle after the last product is accepted.
//      A cycle with prod_valid=0 is a stall: no change.
//  - DONE: acc_valid=1, prod_ready=0. acc_out and overflow hold until acc_valid&&acc_ready.
//      On that edge: acc_valid goes to 0, state goes to IDLE. acc_out and overflow keep their values until the next start.
//  - start is ignored outside IDLE. If len is 0 and start is not asserted, nothing happens.
//  - clear=1 in any state: next edge state=IDLE, acc_valid=0, prod_ready=0, rem=0. acc_out and overflow are not modified.
//      clear has priority over start and over a simultaneous transfer; the product is discarded.
//  - Back-to-back operation: start may be asserted in the IDLE cycle right after the DONE handshake.
//      The minimum gap between bursts is 1 cycle.
//  - Adds are unsigned. Wrap is modulo 2^ACC_W, and the wrap is recorded by overflow. The block does not saturate.
// TESTING
//  1 Reset: assert rst_n=0 mid-ACCUM, asynchronously -> all outputs 0 immediately; state IDLE.
//  2 Basic: start, len=3; prod=1,2,3, one per cycle -> acc_valid 1 cycle after 3rd; acc_out=6; overflow=0.
//  3 Stalls and backpressure: len=2; prod_valid gapped by 3 idle cycles; acc_ready held low 5 cycles
//      -> acc_out=0xAAAA..AA*0x5555..55 + 1 held stable while waiting; a single handshake; then IDLE.
//  4 Overflow: len=257; every prod = 2^128-1 -> overflow=1; acc_out = 2^128-257. With len=256 -> overflow=0.
//  5 Zero length: start with len=0 -> acc_valid=1 next cycle; acc_out=0; prod_ready never asserted.
//  6 Abort and ignore: clear during the 2nd of 4 products -> IDLE next cycle; that product is not added.
//      start issued during ACCUM is ignored, and rem is unchanged.

Source files
------------

// File: rtl/mul64_dot_acc.sv
// Dot-product reduction stage: sums a burst of unsigned products into a wide accumulator
// and presents the final sum over a valid/ready handshake, with a sticky overflow flag.
module mul64_dot_acc #(
  parameter int PROD_W = 128,
  parameter int ACC_W  = 136,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_rem;

  logic               w_xfer;
  logic               w_last;
  logic [ACC_W:0]     w_sum;

  // Handshake outputs decode straight from state, so they carry no extra flop.
  assign prod_ready = (r_state == S_ACCUM);
  assign acc_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign acc_out    = r_acc;
  assign overflow   = r_ovf;

  assign w_xfer = prod_ready && prod_valid;
  assign w_last = (r_rem == CNT_W'(1));

  // One extra bit on the adder captures the carry that leaves bit ACC_W-1.
  assign w_sum = {1'b0, r_acc} + {{(ACC_W - PROD_W + 1){1'b0}}, prod};

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_xfer && w_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (acc_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: clear only drops the remaining count; the last sum and flag stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_rem <= '0;
    end else if (clear) begin
      r_rem <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_rem <= len;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            r_rem <= r_rem - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul64_dot_acc.sv
// Self-checking bench for mul64_dot_acc: table-driven bursts, hand-written corner cases,
// and randomized bursts scored against an exact-arithmetic sum model.
module tb_mul64_dot_acc;
  localparam int PROD_W = 128;
  localparam int ACC_W  = 136;
  localparam int CNT_W  = 16;
  localparam int BIG_W  = 160;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              clear;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              overflow;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [PROD_W-1:0] q_prod[$];

  mul64_dot_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact (non-wrapping) sum of the queued products; the DUT must match it modulo 2^ACC_W.
  function automatic logic [BIG_W-1:0] exact_sum();
    logic [BIG_W-1:0] s = '0;
    foreach (q_prod[i]) s += BIG_W'(q_prod[i]);
    return s;
  endfunction

  // Drive one burst from q_prod, then hold acc_ready low for ready_dly cycles before the handshake.
  task automatic burst(input string name, input int n, input int min_stall, input int max_stall,
                       input int ready_dly, input logic [ACC_W-1:0] exp_acc, input logic exp_ovf);
    @(negedge clk);
    start = 1'b1;
    len   = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    if (n > 0) begin
      check({name, "_busy"}, ACC_W'(busy), ACC_W'(1));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(max_stall, min_stall)) begin
          prod_valid = 1'b0;
          prod       = PROD_W'($urandom);
          @(negedge clk);
        end
        prod_valid = 1'b1;
        prod       = q_prod[i];
        if (prod_ready !== 1'b1) check({name, "_prod_ready"}, ACC_W'(prod_ready), ACC_W'(1));
        @(negedge clk);
      end
      prod_valid = 1'b0;
    end else begin
      check({name, "_zl_prod_ready"}, ACC_W'(prod_ready), ACC_W'(0));
    end
    check({name, "_acc_valid"}, ACC_W'(acc_valid), ACC_W'(1));
    check({name, "_acc_out"}, acc_out, exp_acc);
    check({name, "_overflow"}, ACC_W'(overflow), ACC_W'(exp_ovf));
    for (int d = 0; d < ready_dly; d++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, ACC_W'(acc_valid), ACC_W'(1));
      check({name, "_hold_acc"}, acc_out, exp_acc);
      check({name, "_hold_rdy"}, ACC_W'(prod_ready), ACC_W'(0));
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check({name, "_post_valid"}, ACC_W'(acc_valid), ACC_W'(0));
    check({name, "_post_busy"}, ACC_W'(busy), ACC_W'(0));
    check({name, "_post_acc"}, acc_out, exp_acc);
    check({name, "_post_ovf"}, ACC_W'(overflow), ACC_W'(exp_ovf));
  endtask

  typedef enum int { P_INC, P_MAX } kind_t;
  typedef struct {
    int               n;
    kind_t            kind;
    logic [ACC_W-1:0] exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t tbl[6];
  logic [PROD_W-1:0] pmax;
  logic [63:0]       a_aa;
  logic [63:0]       b_55;
  logic [PROD_W-1:0] p_ab;
  logic [BIG_W-1:0]  s_big;
  logic [BIG_W-1:0]  lim;

  initial begin
    pmax = '1;
    lim  = BIG_W'(1) << ACC_W;
    tbl[0] = '{3,   P_INC, ACC_W'(6), 1'b0};
    tbl[1] = '{0,   P_INC, ACC_W'(0), 1'b0};
    tbl[2] = '{256, P_MAX, (ACC_W'(256) << 128) - ACC_W'(256), 1'b0};
    tbl[3] = '{257, P_MAX, (ACC_W'(1) << 128) - ACC_W'(257), 1'b1};
    tbl[4] = '{1,   P_MAX, ACC_W'(pmax), 1'b0};
    tbl[5] = '{258, P_MAX, (ACC_W'(2) << 128) - ACC_W'(258), 1'b1};

    rst_n = 1'b0; start = 1'b0; len = '0; clear = 1'b0;
    prod = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    #12;
    check("rst_acc_out", acc_out, '0);
    check("rst_flags", ACC_W'({acc_valid, prod_ready, overflow, busy}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven bursts, back to back.
    foreach (tbl[t]) begin
      q_prod.delete();
      for (int i = 0; i < tbl[t].n; i++)
        q_prod.push_back(tbl[t].kind == P_INC ? PROD_W'(i + 1) : pmax);
      burst($sformatf("tbl%0d", t), tbl[t].n, 0, 0, t % 2, tbl[t].exp_acc, tbl[t].exp_ovf);
    end

    // Stalls and backpressure: AA..AA*55..55 then 1, three idle cycles before each product.
    a_aa = 64'hAAAA_AAAA_AAAA_AAAA;
    b_55 = 64'h5555_5555_5555_5555;
    p_ab = PROD_W'(a_aa) * PROD_W'(b_55);
    q_prod.delete();
    q_prod.push_back(p_ab);
    q_prod.push_back(PROD_W'(1));
    burst("stall", 2, 3, 3, 5, ACC_W'(p_ab) + ACC_W'(1), 1'b0);

    // Abort: clear during the 2nd of 4 products, with start also high.
    @(negedge clk);
    start = 1'b1; len = CNT_W'(4);
    @(negedge clk);
    start = 1'b0; len = '0;
    prod_valid = 1'b1; prod = PROD_W'(10);
    @(negedge clk);
    prod = PROD_W'(20); clear = 1'b1; start = 1'b1; len = CNT_W'(2);
    @(negedge clk);
    clear = 1'b0; start = 1'b0; len = '0; prod_valid = 1'b0;
    check("abort_busy", ACC_W'(busy), '0);
    check("abort_rdy_valid", ACC_W'({prod_ready, acc_valid}), '0);
    check("abort_acc", acc_out, ACC_W'(10));
    @(negedge clk);
    check("abort_stays_idle", ACC_W'(busy), '0);

    // Ignore start during ACCUM: len=3 burst with start/len=9 on the first product.
    @(negedge clk);
    start = 1'b1; len = CNT_W'(3);
    @(negedge clk);
    len = CNT_W'(9); prod_valid = 1'b1; prod = PROD_W'(7);
    @(negedge clk);
    start = 1'b0; len = '0; prod = PROD_W'(8);
    @(negedge clk);
    prod = PROD_W'(9);
    @(negedge clk);
    prod_valid = 1'b0;
    check("ign_valid", ACC_W'(acc_valid), ACC_W'(1));
    check("ign_acc", acc_out, ACC_W'(24));
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check("ign_idle", ACC_W'(busy), '0);

    // Asynchronous reset mid-ACCUM, applied between clock edges.
    @(negedge clk);
    start = 1'b1; len = CNT_W'(4);
    @(negedge clk);
    start = 1'b0; len = '0; prod_valid = 1'b1; prod = PROD_W'(5);
    @(negedge clk);
    @(negedge clk);
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc_out", acc_out, '0);
    check("arst_flags", ACC_W'({acc_valid, prod_ready, overflow, busy}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_held", ACC_W'(busy), '0);

    // Randomized bursts against the exact-sum model.
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(8, 1);
      q_prod.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) == 0) q_prod.push_back(pmax);
        else q_prod.push_back({$urandom, $urandom, $urandom, $urandom});
      end
      s_big = exact_sum();
      burst($sformatf("rnd%0d", r), n, 0, 2, $urandom_range(3, 0),
            s_big[ACC_W-1:0], s_big >= lim);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
